connect4_turn_ctrl: RTL and testbench
=====================================

Name: connect4_turn_ctrl

Overview:
Turn sequencer and move arbiter placed in front of the Connect Four board datapath. It accepts column requests from two player ports and enforces strict turn order. Each legal move is validated as one-hot and against a full column, then issued to the board as a single start pulse. After the board settles, the controller samples winner/error and tracks move count, draw and game-over.

Parameters:
SETTLE_CYC, 2, cycles between the board start pulse and sampling winner/error (1..15).
FIRST_PLAYER, 0, player that moves first after new_game.
TIMEOUT_CYC, 255, idle cycles before a turn is forfeited (used only with the optional feature).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
new_game  input  1  pulse: start a new game
req0  input  1  player 0 move request
col0  input  8  player 0 column, one-hot, bit7 = leftmost
req1  input  1  player 1 move request
col1  input  8  player 1 column, one-hot
occ  input  64  board occupancy, bit r*8+c set = cell filled, row 7 = top
brd_winner  input  2  board result: 00 none, 01 P0, 10 P1, 11 reserved
brd_error  input  1  board rejected the move
ack0  output  1  pulse: player 0 move accepted
nack0  output  1  pulse: player 0 request rejected
ack1  output  1  pulse: player 1 move accepted
nack1  output  1  pulse: player 1 request rejected
brd_col  output  8  column to the board (player_input)
brd_player  output  1  mover id to the board
brd_start  output  1  one-cycle move strobe
cur_player  output  1  player whose turn it is
move_cnt  output  7  accepted moves this game, 0..64
result  output  2  00 in progress, 01 P0 wins, 10 P1 wins, 11 draw
game_over  output  1  high while in GAME_OVER

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0, except cur_player = FIRST_PLAYER.
- IDLE: on new_game, clear move_cnt and result, set cur_player = FIRST_PLAYER, go to WAIT_MOVE.
- WAIT_MOVE: only the req of cur_player is considered.
  - An off-turn req produces nack for that player the same cycle and is otherwise ignored.
  - An on-turn req with a col that is not one-hot (zero or multiple bits) gives nack and stays in WAIT_MOVE.
  - An on-turn req with occ[56+c] set (column full) gives nack and stays in WAIT_MOVE.
  - A legal on-turn req gives ack, registers brd_col and brd_player, and goes to ISSUE.
  - Ack/nack are registered: asserted the cycle after req is sampled, for one cycle.
  - Simultaneous req0 and req1: on-turn player served; off-turn player gets nack.
- ISSUE: brd_start = 1 for exactly one cycle, then go to SETTLE.
  - brd_col and brd_player hold stable from ISSUE until the next ack.
- SETTLE: wait SETTLE_CYC cycles, then go to CHECK.
- CHECK: evaluate in priority order.
  1. brd_error = 1: no count change, same player retries, go to WAIT_MOVE.
  2. brd_winner = 01/10: result = brd_winner, go to GAME_OVER.
  3. move_cnt + 1 == 64: result = 11 (draw), go to GAME_OVER.
  4. Otherwise: increment move_cnt, toggle cur_player, go to WAIT_MOVE.
  - move_cnt also increments on a win or draw; it saturates at 64.
- GAME_OVER: game_over = 1 and result holds. Every req gets nack. new_game restarts as in IDLE.
- new_game in any other state aborts the game: return to the IDLE-restart actions next cycle. An in-flight brd_start is not repeated.
- reset mid-move: immediate return to reset values; no brd_start glitch.

Optional Feature:
TURN_TIMEOUT_EN:
- Defined: a counter in WAIT_MOVE increments each cycle with no legal on-turn req.
  - On reaching TIMEOUT_CYC, cur_player toggles (turn forfeited) and move_cnt is unchanged.
  - The counter clears on any state change or turn change.
- Undefined: no counter; a turn waits indefinitely.

Decomposition:
- Package connect4_pkg holds:
  - the state enumeration (IDLE, WAIT_MOVE, ISSUE, SETTLE, CHECK, GAME_OVER);
  - result encodings RES_NONE/RES_P0/RES_P1/RES_DRAW;
  - BOARD_W = 8, BOARD_CELLS = 64.
- One sub-module, connect4_move_check: purely combinational. Takes col and occ; produces onehot_ok, col_full and col_idx[2:0].

Test Plan:
- Reset, then new_game: P0 req col 8'b10000000 with occ = 0. Expect ack0, then brd_start one cycle later with brd_col = 8'h80 and brd_player = 0. After settle, move_cnt = 1 and cur_player = 1.
- Turn order: while cur_player = 0, req1 with col 8'h01. Expect nack1, no brd_start, cur_player unchanged.
- Illegal column: col0 = 8'b00000000 and, separately, 8'b00011000 each give nack0. occ[63] = 1 with col0 = 8'h01 gives nack0.
- Win: alternate 7 legal moves; brd_winner = 01 in the 7th CHECK. Expect result = 01, game_over = 1, move_cnt = 7; subsequent req0 gets nack0.
- Draw: force 64 accepted moves with brd_winner = 00. Expect result = 11 and move_cnt = 64. Then new_game returns move_cnt = 0 and result = 00.
- Reset asserted during SETTLE: outputs clear asynchronously, no further brd_start. With TURN_TIMEOUT_EN and TIMEOUT_CYC = 4, no req gives cur_player toggle after 4 cycles.

Source files
------------

// File: rtl/connect4_pkg.sv
// connect4_pkg: shared definitions for the Connect Four turn controller.
//   - state_e     : turn controller FSM states
//   - RES_*       : encodings of the game result output
//   - BOARD_W     : number of columns (and rows) on the board
//   - BOARD_CELLS : total number of board cells
package connect4_pkg;

    localparam int BOARD_W     = 8;
    localparam int BOARD_CELLS = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_MOVE = 3'd1,
        ISSUE     = 3'd2,
        SETTLE    = 3'd3,
        CHECK     = 3'd4,
        GAME_OVER = 3'd5
    } state_e;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P0   = 2'b01;
    localparam logic [1:0] RES_P1   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

endpackage

// File: rtl/connect4_move_check.sv
// connect4_move_check: combinational legality check of a requested column.
// Ports:
//   col_i       [7:0]  requested column, one-hot, bit7 = leftmost
//   occ_i       [63:0] board occupancy, bit r*8+c, row 7 = top
//   onehot_ok_o        exactly one column bit is set
//   col_full_o         top cell of the requested column is occupied
//   col_idx_o   [2:0]  column index c (0 = leftmost)
module connect4_move_check
    import connect4_pkg::*;
(
    input  logic [BOARD_W-1:0]     col_i,
    input  logic [BOARD_CELLS-1:0] occ_i,
    output logic                   onehot_ok_o,
    output logic                   col_full_o,
    output logic [2:0]             col_idx_o
);

    // Only the top row decides whether a column can take another disc.
    logic unused_occ;
    assign unused_occ = ^occ_i[BOARD_CELLS-BOARD_W-1:0];

    always_comb begin
        onehot_ok_o = (col_i != '0) && ((col_i & (col_i - 8'd1)) == '0);
        col_idx_o   = 3'd0;
        // Column bit 7 is the leftmost column (c = 0), so c = 7 - bit.
        for (int i = 0; i < BOARD_W; i++) begin
            if (col_i[i]) begin
                col_idx_o = 3'(BOARD_W - 1 - i);
            end
        end
        // Top-row cell of column c sits at bit 56 + c.
        col_full_o = onehot_ok_o && occ_i[{3'b111, col_idx_o}];
    end

endmodule

// File: rtl/connect4_turn_ctrl.sv
// connect4_turn_ctrl: turn sequencer and move arbiter in front of the
// Connect Four board datapath.
// Optional feature macro: TURN_TIMEOUT_EN (turn forfeit after TIMEOUT_CYC
// idle cycles in WAIT_MOVE); without it a turn waits indefinitely.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   new_game              start/restart a game
//   req0/col0, req1/col1  player move requests with one-hot column
//   occ                   board occupancy (bit r*8+c, row 7 = top)
//   brd_winner/brd_error  board result, sampled SETTLE_CYC after brd_start
//   ack0/nack0/ack1/nack1 registered one-cycle request responses
//   brd_col/brd_player    move issued to the board, held until next ack
//   brd_start             one-cycle move strobe to the board
//   cur_player, move_cnt, result, game_over  game status
//   dbg_state             current FSM state (connect4_pkg::state_e)
// Handshake: a request is a level sampled on a clock edge; the response
// (exactly one of ack/nack for that player) appears for one cycle after it.
module connect4_turn_ctrl
    import connect4_pkg::*;
#(
    parameter int   SETTLE_CYC   = 2,
    parameter logic FIRST_PLAYER = 1'b0,
    parameter int   TIMEOUT_CYC  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_game,
    input  logic        req0,
    input  logic [7:0]  col0,
    input  logic        req1,
    input  logic [7:0]  col1,
    input  logic [63:0] occ,
    input  logic [1:0]  brd_winner,
    input  logic        brd_error,
    output logic        ack0,
    output logic        nack0,
    output logic        ack1,
    output logic        nack1,
    output logic [7:0]  brd_col,
    output logic        brd_player,
    output logic        brd_start,
    output logic        cur_player,
    output logic [6:0]  move_cnt,
    output logic [1:0]  result,
    output logic        game_over,
    output logic [2:0]  dbg_state
);

    state_e      state_q, state_d;
    logic        cur_q, cur_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [1:0]  res_q, res_d;
    logic [7:0]  col_q, col_d;
    logic        pl_q, pl_d;
    logic        start_q, start_d;
    logic        ack0_q, ack0_d, nack0_q, nack0_d;
    logic        ack1_q, ack1_d, nack1_q, nack1_d;
    logic [3:0]  set_q, set_d;

`ifdef TURN_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_W-1:0] to_q, to_d;
    logic            to_expire;
    assign to_expire = (to_q == TO_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    // Only the player whose turn it is can have a move evaluated.
    logic       req_on, req_off;
    logic [7:0] col_on;
    logic       onehot_ok, col_full, legal;
    logic [2:0] col_idx;
    logic [6:0] cnt_inc;

    assign req_on  = cur_q ? req1 : req0;
    assign req_off = cur_q ? req0 : req1;
    assign col_on  = cur_q ? col1 : col0;
    assign legal   = onehot_ok && !col_full;
    // Winning or drawing moves still count; the counter stops at 64.
    assign cnt_inc = (cnt_q == 7'(BOARD_CELLS)) ? cnt_q : cnt_q + 7'd1;

    connect4_move_check u_move_check (
        .col_i       (col_on),
        .occ_i       (occ),
        .onehot_ok_o (onehot_ok),
        .col_full_o  (col_full),
        .col_idx_o   (col_idx)
    );

    logic unused_idx;
    assign unused_idx = ^col_idx;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        col_d   = col_q;
        pl_d    = pl_q;
        start_d = 1'b0;
        ack0_d  = 1'b0;
        nack0_d = 1'b0;
        ack1_d  = 1'b0;
        nack1_d = 1'b0;
        set_d   = set_q;
`ifdef TURN_TIMEOUT_EN
        to_d    = '0;
`endif
        // new_game overrides everything, including a pending brd_start.
        if (new_game) begin
            state_d = WAIT_MOVE;
            cnt_d   = '0;
            res_d   = RES_NONE;
            cur_d   = FIRST_PLAYER;
            set_d   = '0;
        end else begin
            case (state_q)
                IDLE: ;
                WAIT_MOVE: begin
                    if (req_off) begin
                        if (cur_q) nack0_d = 1'b1;
                        else       nack1_d = 1'b1;
                    end
                    if (req_on) begin
                        if (legal) begin
                            if (cur_q) ack1_d = 1'b1;
                            else       ack0_d = 1'b1;
                            col_d   = col_on;
                            pl_d    = cur_q;
                            state_d = ISSUE;
                        end else begin
                            if (cur_q) nack1_d = 1'b1;
                            else       nack0_d = 1'b1;
                        end
                    end
`ifdef TURN_TIMEOUT_EN
                    if (!(req_on && legal)) begin
                        if (to_expire) begin
                            cur_d = ~cur_q;
                        end else begin
                            to_d = to_q + TO_W'(1);
                        end
                    end
`endif
                end
                ISSUE: begin
                    start_d = 1'b1;
                    set_d   = '0;
                    state_d = SETTLE;
                end
                SETTLE: begin
                    if (set_q == 4'(SETTLE_CYC - 1)) state_d = CHECK;
                    else                             set_d   = set_q + 4'd1;
                end
                CHECK: begin
                    if (brd_error) begin
                        state_d = WAIT_MOVE;
                    end else begin
                        cnt_d = cnt_inc;
                        if (brd_winner == RES_P0 || brd_winner == RES_P1) begin
                            res_d   = brd_winner;
                            state_d = GAME_OVER;
                        end else if (cnt_q == 7'(BOARD_CELLS - 1)) begin
                            res_d   = RES_DRAW;
                            state_d = GAME_OVER;
                        end else begin
                            cur_d   = ~cur_q;
                            state_d = WAIT_MOVE;
                        end
                    end
                end
                GAME_OVER: begin
                    nack0_d = req0;
                    nack1_d = req1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= FIRST_PLAYER;
            cnt_q   <= '0;
            res_q   <= RES_NONE;
            col_q   <= '0;
            pl_q    <= 1'b0;
            start_q <= 1'b0;
            ack0_q  <= 1'b0;
            nack0_q <= 1'b0;
            ack1_q  <= 1'b0;
            nack1_q <= 1'b0;
            set_q   <= '0;
`ifdef TURN_TIMEOUT_EN
            to_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            col_q   <= col_d;
            pl_q    <= pl_d;
            start_q <= start_d;
            ack0_q  <= ack0_d;
            nack0_q <= nack0_d;
            ack1_q  <= ack1_d;
            nack1_q <= nack1_d;
            set_q   <= set_d;
`ifdef TURN_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end

    assign ack0       = ack0_q;
    assign nack0      = nack0_q;
    assign ack1       = ack1_q;
    assign nack1      = nack1_q;
    assign brd_col    = col_q;
    assign brd_player = pl_q;
    assign brd_start  = start_q;
    assign cur_player = cur_q;
    assign move_cnt   = cnt_q;
    assign result     = res_q;
    assign game_over  = (state_q == GAME_OVER);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_connect4_turn_ctrl.sv
module tb_connect4_turn_ctrl;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        reset, new_game, req0, req1, brd_error;
    logic [7:0]  col0, col1;
    logic [63:0] occ;
    logic [1:0]  brd_winner;
    logic        ack0, nack0, ack1, nack1, brd_player, brd_start;
    logic        cur_player, game_over;
    logic [7:0]  brd_col;
    logic [6:0]  move_cnt;
    logic [1:0]  result;
    logic [2:0]  dbg_state;

    connect4_turn_ctrl #(.SETTLE_CYC(SETTLE), .FIRST_PLAYER(1'b0), .TIMEOUT_CYC(255)) dut (
        .clk(clk), .reset(reset), .new_game(new_game),
        .req0(req0), .col0(col0), .req1(req1), .col1(col1),
        .occ(occ), .brd_winner(brd_winner), .brd_error(brd_error),
        .ack0(ack0), .nack0(nack0), .ack1(ack1), .nack1(nack1),
        .brd_col(brd_col), .brd_player(brd_player), .brd_start(brd_start),
        .cur_player(cur_player), .move_cnt(move_cnt), .result(result),
        .game_over(game_over), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // scoreboard and game model
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    bit         m_cur;
    int         m_cnt;
    logic [1:0] m_res;
    bit         m_over;
    int         heights[8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_onehot(input logic [7:0] c);
        int n = 0;
        for (int i = 0; i < 8; i++) if (c[i]) n++;
        return n == 1;
    endfunction

    function automatic int col_index(input logic [7:0] c);
        for (int i = 0; i < 8; i++) if (c[i]) return 7 - i;
        return 0;
    endfunction

    function automatic logic [63:0] occ_of();
        logic [63:0] o = '0;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < heights[c]; r++) o[r*8+c] = 1'b1;
        return o;
    endfunction

    task automatic model_clear();
        m_cur = 1'b0; m_cnt = 0; m_res = 2'b00; m_over = 1'b0;
        for (int c = 0; c < 8; c++) heights[c] = 0;
        exp_q.delete();
    endtask

    task automatic check_status();
        check("move_cnt", 32'(move_cnt), 32'(m_cnt));
        check("cur_player", 32'(cur_player), 32'(m_cur));
        check("result", 32'(result), 32'(m_res));
        check("game_over", 32'(game_over), 32'(m_over));
    endtask

    // driver tasks
    task automatic do_new_game();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
        occ = occ_of();
        check_status();
    endtask

    task automatic try_move(input bit p, input logic [7:0] col, input bit also_off,
                            input logic [7:0] off_col, input logic [1:0] win, input bit err);
        bit legal;
        int c;
        logic [3:0] exp_resp;
        occ        = occ_of();
        brd_winner = win;
        brd_error  = err;
        if (p) begin
            req1 = 1'b1; col1 = col;
            if (also_off) begin req0 = 1'b1; col0 = off_col; end
        end else begin
            req0 = 1'b1; col0 = col;
            if (also_off) begin req1 = 1'b1; col1 = off_col; end
        end
        c     = col_index(col);
        legal = !m_over && (p == m_cur) && is_onehot(col) && (heights[c] < 8);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        // {ack0, nack0, ack1, nack1}
        exp_resp = p ? {1'b0, also_off, legal, !legal} : {legal, !legal, 1'b0, also_off};
        check("ack_nack", 32'({ack0, nack0, ack1, nack1}), 32'(exp_resp));
        check("no_start_at_ack", 32'(brd_start), 32'd0);
        if (legal) begin
            exp_q.push_back(col);
            @(negedge clk);
            check("brd_start", 32'(brd_start), 32'd1);
            check("brd_col", 32'(brd_col), 32'(exp_q.pop_front()));
            check("brd_player", 32'(brd_player), 32'(p));
            for (int i = 0; i < SETTLE; i++) begin
                @(negedge clk);
                check("start_one_cycle", 32'(brd_start), 32'd0);
                check("cnt_during_settle", 32'(move_cnt), 32'(m_cnt));
            end
            @(negedge clk);
            if (!err) begin
                heights[c]++;
                if (m_cnt < 64) m_cnt++;
                if (win == 2'b01 || win == 2'b10) begin
                    m_res = win; m_over = 1'b1;
                end else if (m_cnt == 64) begin
                    m_res = 2'b11; m_over = 1'b1;
                end else begin
                    m_cur = !m_cur;
                end
            end
        end
        check_status();
        brd_winner = 2'b00;
        brd_error  = 1'b0;
    endtask

    function automatic logic [7:0] open_col();
        int c;
        do c = $urandom_range(0, 7); while (heights[c] == 8);
        return 8'h80 >> c;
    endfunction

    // main sequence
    initial begin
        int kind, a, b;
        bit p, also, err;
        logic [7:0] col, off_col;
        logic [1:0] win;

        reset = 1'b1; new_game = 1'b0; req0 = 1'b0; req1 = 1'b0;
        col0 = '0; col1 = '0; occ = '0; brd_winner = 2'b00; brd_error = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check("rst_outputs", 32'({ack0, nack0, ack1, nack1, brd_start, brd_player}), 32'd0);
        check("rst_brd_col", 32'(brd_col), 32'd0);
        check_status();
        reset = 1'b0;
        @(negedge clk);
        do_new_game();

        // first legal move, turn order, illegal columns
        try_move(1'b0, 8'h80, 1'b0, 8'h00, 2'b00, 1'b0);
        try_move(1'b0, 8'h01, 1'b0, 8'h00, 2'b00, 1'b0);
        try_move(1'b1, 8'h00, 1'b0, 8'h00, 2'b00, 1'b0);
        try_move(1'b1, 8'h18, 1'b0, 8'h00, 2'b00, 1'b0);
        try_move(1'b1, 8'h01, 1'b0, 8'h00, 2'b00, 1'b0);
        try_move(1'b1, 8'h01, 1'b0, 8'h00, 2'b00, 1'b0);
        try_move(1'b0, 8'h40, 1'b1, 8'h02, 2'b00, 1'b0);
        try_move(1'b1, 8'h20, 1'b0, 8'h00, 2'b00, 1'b1);
        try_move(1'b1, 8'h20, 1'b0, 8'h00, 2'b00, 1'b0);

        // win by P0 on the 7th move
        do_new_game();
        for (int i = 0; i < 7; i++)
            try_move(m_cur, (i % 2 == 0) ? 8'h10 : 8'h08, 1'b0, 8'h00,
                     (i == 6) ? 2'b01 : 2'b00, 1'b0);
        check("win_cnt", 32'(move_cnt), 32'd7);
        try_move(1'b0, 8'h04, 1'b0, 8'h00, 2'b00, 1'b0);
        try_move(1'b1, 8'h04, 1'b0, 8'h00, 2'b00, 1'b0);

        // draw: fill the board, probing a full column on the way
        do_new_game();
        for (int c = 7; c >= 0; c--) begin
            for (int r = 0; r < 8; r++) try_move(m_cur, 8'h80 >> c, 1'b0, 8'h00, 2'b00, 1'b0);
            if (c == 7) try_move(m_cur, 8'h01, 1'b0, 8'h00, 2'b00, 1'b0);
        end
        check("draw_result", 32'(result), 32'd3);
        check("draw_cnt", 32'(move_cnt), 32'd64);
        do_new_game();

        // randomized games
        repeat (250) begin
            if (m_over) do_new_game();
            kind = $urandom_range(0, 9);
            p = m_cur; also = 1'b0; off_col = 8'h00;
            col = open_col();
            if (kind == 6) begin
                a = $urandom_range(0, 7);
                b = (a + $urandom_range(1, 7)) % 8;
                col = ($urandom_range(0, 1) == 0) ? 8'h00 : ((8'h80 >> a) | (8'h80 >> b));
            end else if (kind == 7) begin
                for (int c = 0; c < 8; c++) if (heights[c] == 8) col = 8'h80 >> c;
            end else if (kind == 8) begin
                p = !m_cur;
            end else if (kind == 9) begin
                also = 1'b1;
                off_col = 8'(1 << $urandom_range(0, 7));
            end
            win = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
            err = ($urandom_range(0, 9) == 0);
            try_move(p, col, also, off_col, win, err);
        end

        // new_game during SETTLE aborts the move
        do_new_game();
        req0 = 1'b1; col0 = 8'h80; occ = occ_of();
        @(negedge clk);
        req0 = 1'b0;
        check("abort_ack", 32'({ack0, nack0, ack1, nack1}), 32'b1000);
        @(negedge clk);
        check("abort_start", 32'(brd_start), 32'd1);
        do_new_game();
        repeat (SETTLE + 3) begin
            check("abort_no_start", 32'(brd_start), 32'd0);
            @(negedge clk);
        end
        check_status();
        try_move(1'b0, 8'h02, 1'b0, 8'h00, 2'b00, 1'b0);

        // reset asserted during SETTLE
        req1 = 1'b1; col1 = 8'h04; occ = occ_of();
        @(negedge clk);
        req1 = 1'b0;
        check("rst_mid_ack", 32'({ack0, nack0, ack1, nack1}), 32'b0010);
        @(negedge clk);
        check("rst_mid_start", 32'(brd_start), 32'd1);
        #2 reset = 1'b1;
        #1;
        model_clear();
        check_status();
        check("rst_mid_brd", 32'({brd_col, brd_player, brd_start}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        req0 = 1'b1; col0 = 8'h80;
        repeat (SETTLE + 4) begin
            @(negedge clk);
            check("idle_no_start", 32'(brd_start), 32'd0);
            check("idle_no_resp", 32'({ack0, nack0, ack1, nack1}), 32'd0);
        end
        req0 = 1'b0;
        check_status();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
